clk_freq_monitor: RTL and testbench
===================================

CLK_FREQ_MONITOR -- requirements
Module: clk_freq_monitor

Interface
REQ-001 Parameters, one per line: N_CH, default 2, number of monitored external clocks.
REQ-002 CNT_W, default 16, per-channel count width; must exceed log2 of the maximum edges per window.
REQ-003 WIN_CYC, default 65536, gate window length in CLK_LOW cycles (>=16).
REQ-004 GOOD_WIN, default 4, consecutive in-range windows to assert valid (hysteresis build only).
REQ-005 BAD_WIN, default 2, consecutive out-of-range windows to deassert valid (hysteresis build only).
REQ-006 Ports, one per line: CLK_LOW  in  1  monitor clock, all outputs in this domain.
REQ-007 ext_clk_cnt_rst2  in  1  asynchronous, active-high reset for the CLK_LOW domain.
REQ-008 EXT_CLK  in  N_CH  monitored clocks, one per channel, mutually asynchronous to CLK_LOW.
REQ-009 LO_THR  in  N_CH*CNT_W  per-channel inclusive lower count bound, quasi-static.
REQ-010 HI_THR  in  N_CH*CNT_W  per-channel inclusive upper count bound, quasi-static.
REQ-011 MEAS_CNT  out  N_CH*CNT_W  last completed window edge count per channel.
REQ-012 MEAS_STB  out  1  one-cycle pulse when MEAS_CNT and CLK_VALID update.
REQ-013 CLK_VALID  out  N_CH  per-channel frequency-in-range flag.
REQ-014 VALID_CHG  out  N_CH  one-cycle pulse on any CLK_VALID transition of that channel.

Function
REQ-015 Each channel SHALL run a free-running CNT_W-bit Gray counter clocked by its EXT_CLK; it is not reset and wraps modulo 2^CNT_W.
REQ-016 Each Gray count SHALL pass a 2-flop synchronizer into CLK_LOW, then convert to binary.
REQ-017 A window counter SHALL count 0..WIN_CYC-1 on CLK_LOW and wrap; terminal count (TC) is WIN_CYC-1.
REQ-018 At TC each channel SHALL capture its binary sample as snapshot; count = (sample - previous snapshot) mod 2^CNT_W.
REQ-019 The first TC after reset SHALL only prime snapshots: no MEAS_STB, MEAS_CNT stays 0.
REQ-020 From the second TC on, MEAS_CNT, CLK_VALID and VALID_CHG SHALL update, with MEAS_STB high, exactly one cycle after TC.
REQ-021 A window is in range when LO_THR <= count <= HI_THR, unsigned; LO_THR and HI_THR are sampled at TC.
REQ-022 A stopped EXT_CLK SHALL yield count 0 (out of range unless LO_THR is 0).
REQ-023 If LO_THR > HI_THR for a channel, every window of that channel is out of range.
REQ-024 Per-channel state machine (hysteresis build): LOST -> ACQ on in-range window; ACQ -> LOCKED after GOOD_WIN consecutive in-range windows.
REQ-025 ACQ -> LOST on any out-of-range window, which clears the good counter.
REQ-026 LOCKED -> HOLD on out-of-range window; HOLD -> LOST after BAD_WIN consecutive out-of-range windows; HOLD -> LOCKED on in-range window, which clears the bad counter.
REQ-027 CLK_VALID SHALL be 1 in LOCKED and HOLD, and 0 in LOST and ACQ.
REQ-028 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL pulse all corresponding VALID_CHG bits in the same cycle.

Reset
REQ-029 On ext_clk_cnt_rst2 asserted: window counter, snapshots, MEAS_CNT = 0; MEAS_STB, CLK_VALID, VALID_CHG = 0; all states LOST; prime flag set.
REQ-030 Reset mid-window SHALL abort the window; after release, the next TC is a priming TC again.
REQ-031 Synchronizer flops SHALL be reset; EXT_CLK-domain Gray counters SHALL NOT be reset.

Configuration
REQ-032 Macro CLK_FREQ_MONITOR_HYST_EN defined: REQ-024..REQ-027 state machines apply, using GOOD_WIN and BAD_WIN.
REQ-033 Macro absent: no state machines; CLK_VALID equals the in-range result of the latest window, and GOOD_WIN and BAD_WIN are ignored.

Verification
REQ-034 CLK_LOW 100 MHz, EXT_CLK[0] 10 MHz, WIN_CYC 65536, bounds 6400/6700 -> MEAS_CNT[0] is 6553 or 6554 from the 2nd TC; CLK_VALID[0] rises at the 5th measured window (HYST_EN) or the 1st (no HYST).
REQ-035 Locked channel 0, then EXT_CLK[0] stopped -> MEAS_CNT 0; CLK_VALID[0] falls after 2 windows (HYST_EN) with one VALID_CHG[0] pulse.
REQ-036 Locked channel, one 9 MHz window (5898 counts) then back to 10 MHz -> HYST_EN: CLK_VALID stays 1; no HYST: 1-window dropout with two VALID_CHG pulses.
REQ-037 Gray counter near 0xFFFF at TC (wrap inside window) -> MEAS_CNT still 6553 or 6554.
REQ-038 ext_clk_cnt_rst2 pulsed mid-window while locked -> all outputs 0 immediately; no MEAS_STB at the next TC; measurement resumes at the TC after that.

Source files
------------

// File: rtl/clk_freq_monitor.sv
// clk_freq_monitor: per-channel external clock frequency checker.
// Counts EXT_CLK edges per CLK_LOW gate window and flags in-range clocks.
//
// Ports:
//   CLK_LOW          monitor clock; every output is in this domain
//   ext_clk_cnt_rst2 asynchronous, active-high reset (CLK_LOW domain)
//   EXT_CLK          N_CH monitored clocks, asynchronous to CLK_LOW
//   LO_THR / HI_THR  per-channel inclusive count bounds, sampled at TC
//   MEAS_CNT         last completed window edge count per channel
//   MEAS_STB         one-cycle pulse when MEAS_CNT / CLK_VALID update
//   CLK_VALID        per-channel frequency-in-range flag
//   VALID_CHG        one-cycle pulse on any CLK_VALID transition
//
// Build option: define CLK_FREQ_MONITOR_HYST_EN for the LOST/ACQ/LOCKED/HOLD
// hysteresis state machine. Without it CLK_VALID follows the latest window.
module clk_freq_monitor #(
    parameter int N_CH     = 2,
    parameter int CNT_W    = 16,
    parameter int WIN_CYC  = 65536,
    parameter int GOOD_WIN = 4,
    parameter int BAD_WIN  = 2
) (
    input  logic                  CLK_LOW,
    input  logic                  ext_clk_cnt_rst2,
    input  logic [N_CH-1:0]       EXT_CLK,
    input  logic [N_CH*CNT_W-1:0] LO_THR,
    input  logic [N_CH*CNT_W-1:0] HI_THR,
    output logic [N_CH*CNT_W-1:0] MEAS_CNT,
    output logic                  MEAS_STB,
    output logic [N_CH-1:0]       CLK_VALID,
    output logic [N_CH-1:0]       VALID_CHG
);

    localparam int WIN_W = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
    localparam logic [WIN_W-1:0] WIN_TC = WIN_W'(WIN_CYC - 1);

`ifdef CLK_FREQ_MONITOR_HYST_EN
    localparam logic [1:0] S_LOST   = 2'd0;
    localparam logic [1:0] S_ACQ    = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;
    localparam int GW = (GOOD_WIN > 0) ? $clog2(GOOD_WIN + 1) : 1;
    localparam int BW = (BAD_WIN > 0) ? $clog2(BAD_WIN + 1) : 1;
`endif

    logic [WIN_W-1:0] win_q, win_d;
    logic             prime_q;
    logic             stb_q;
    logic             tc;
    logic             upd;

    assign tc  = (win_q == WIN_TC);
    // The first TC after reset only seeds the snapshots.
    assign upd = tc & ~prime_q;
    assign win_d = tc ? '0 : win_q + 1'b1;

    always_ff @(posedge CLK_LOW or posedge ext_clk_cnt_rst2) begin
        if (ext_clk_cnt_rst2) begin
            win_q   <= '0;
            prime_q <= 1'b1;
            stb_q   <= 1'b0;
        end else begin
            win_q <= win_d;
            stb_q <= upd;
            if (tc) prime_q <= 1'b0;
        end
    end

    assign MEAS_STB = stb_q;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [CNT_W-1:0] bin_q, bin_inc, gray_q;
        logic [CNT_W-1:0] sync1_q, sync2_q, samp;
        logic [CNT_W-1:0] snap_q, meas_q, cnt_w, lo, hi;
        logic             inr, val_q, val_d, chg_q;

        // Free-running EXT_CLK-domain counter; deliberately never reset so
        // the domain needs no reset synchronizer of its own.
        assign bin_inc = bin_q + 1'b1;

        always_ff @(posedge EXT_CLK[c]) begin
            bin_q  <= bin_inc;
            gray_q <= bin_inc ^ (bin_inc >> 1);
        end

        // Gray code changes one bit per edge, so a 2-flop sync is safe.
        always_comb begin
            samp = '0;
            for (int i = 0; i < CNT_W; i++) begin
                samp[i] = ^(sync2_q >> i);
            end
        end

        assign lo    = LO_THR[c*CNT_W +: CNT_W];
        assign hi    = HI_THR[c*CNT_W +: CNT_W];
        assign cnt_w = samp - snap_q;
        assign inr   = (cnt_w >= lo) && (cnt_w <= hi);

`ifdef CLK_FREQ_MONITOR_HYST_EN
        logic [1:0]    st_q, st_d;
        logic [GW-1:0] good_q, good_d;
        logic [BW-1:0] bad_q, bad_d;

        always_comb begin
            st_d   = st_q;
            good_d = good_q;
            bad_d  = bad_q;
            if (upd) begin
                unique case (st_q)
                    S_LOST: begin
                        if (inr) begin
                            st_d   = S_ACQ;
                            good_d = '0;
                        end
                    end
                    S_ACQ: begin
                        if (!inr) begin
                            st_d   = S_LOST;
                            good_d = '0;
                        end else if (int'(good_q) + 1 >= GOOD_WIN) begin
                            st_d   = S_LOCKED;
                            good_d = '0;
                        end else begin
                            good_d = good_q + 1'b1;
                        end
                    end
                    S_LOCKED: begin
                        // The window that leaves LOCKED is the first bad one.
                        if (!inr) begin
                            if (BAD_WIN <= 1) begin
                                st_d  = S_LOST;
                                bad_d = '0;
                            end else begin
                                st_d  = S_HOLD;
                                bad_d = BW'(1);
                            end
                        end
                    end
                    S_HOLD: begin
                        if (inr) begin
                            st_d  = S_LOCKED;
                            bad_d = '0;
                        end else if (int'(bad_q) + 1 >= BAD_WIN) begin
                            st_d  = S_LOST;
                            bad_d = '0;
                        end else begin
                            bad_d = bad_q + 1'b1;
                        end
                    end
                    default: st_d = S_LOST;
                endcase
            end
        end

        assign val_d = (st_d == S_LOCKED) || (st_d == S_HOLD);

        always_ff @(posedge CLK_LOW or posedge ext_clk_cnt_rst2) begin
            if (ext_clk_cnt_rst2) begin
                st_q   <= S_LOST;
                good_q <= '0;
                bad_q  <= '0;
            end else begin
                st_q   <= st_d;
                good_q <= good_d;
                bad_q  <= bad_d;
            end
        end
`else
        assign val_d = upd ? inr : val_q;
`endif

        always_ff @(posedge CLK_LOW or posedge ext_clk_cnt_rst2) begin
            if (ext_clk_cnt_rst2) begin
                sync1_q <= '0;
                sync2_q <= '0;
                snap_q  <= '0;
                meas_q  <= '0;
                val_q   <= 1'b0;
                chg_q   <= 1'b0;
            end else begin
                sync1_q <= gray_q;
                sync2_q <= sync1_q;
                if (tc) snap_q <= samp;
                if (upd) meas_q <= cnt_w;
                val_q <= val_d;
                chg_q <= upd & (val_d ^ val_q);
            end
        end

        assign MEAS_CNT[c*CNT_W +: CNT_W] = meas_q;
        assign CLK_VALID[c] = val_q;
        assign VALID_CHG[c] = chg_q;
    end

endmodule

// File: tb/tb_clk_freq_monitor.sv
// tb_clk_freq_monitor: directed + randomized check of clk_freq_monitor.
// Expected counts come from window length / clock period arithmetic.
`timescale 1ns/1ps
module tb_clk_freq_monitor;

    localparam int N_CH     = 2;
    localparam int CNT_W    = 8;
    localparam int WIN_CYC  = 256;
    localparam int GOOD_WIN = 4;
    localparam int BAD_WIN  = 2;
    localparam int T_LOW    = 10;
    localparam int WIN_NS   = WIN_CYC * T_LOW;
    // Edge-count slack from sync latency and mid-window period changes.
    localparam int TOL      = 2;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic ext0 = 1'b0;
    logic ext1 = 1'b0;
    logic [N_CH*CNT_W-1:0] lo_thr = '0;
    logic [N_CH*CNT_W-1:0] hi_thr = '0;
    logic [N_CH*CNT_W-1:0] meas_cnt;
    logic                  meas_stb;
    logic [N_CH-1:0]       clk_valid;
    logic [N_CH-1:0]       valid_chg;

    int per [N_CH] = '{100, 50};
    int pers [5] = '{0, 40, 50, 80, 100};
    int exp_mn [N_CH];
    int exp_mx [N_CH];
    bit exp_in [N_CH];
    int good_run [N_CH];
    int bad_run [N_CH];
    bit vm [N_CH];
    bit primed;
    int n_cmp = 0;
    int n_bad = 0;

    clk_freq_monitor #(
        .N_CH(N_CH), .CNT_W(CNT_W), .WIN_CYC(WIN_CYC),
        .GOOD_WIN(GOOD_WIN), .BAD_WIN(BAD_WIN)
    ) dut (
        .CLK_LOW(clk),
        .ext_clk_cnt_rst2(rst),
        .EXT_CLK({ext1, ext0}),
        .LO_THR(lo_thr),
        .HI_THR(hi_thr),
        .MEAS_CNT(meas_cnt),
        .MEAS_STB(meas_stb),
        .CLK_VALID(clk_valid),
        .VALID_CHG(valid_chg)
    );

    always #(T_LOW/2) clk = ~clk;

    initial begin
        forever begin
            if (per[0] == 0) #1;
            else begin
                #(per[0]/2);
                ext0 = ~ext0;
            end
        end
    end

    initial begin
        forever begin
            if (per[1] == 0) #1;
            else begin
                #(per[1]/2);
                ext1 = ~ext1;
            end
        end
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int mn, input int mx);
        n_cmp++;
        assert ((obs >= mn && obs <= mx) === 1'b1) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, mn, mx);
        end
    endtask

    // Program one channel for the coming window: period (0 = stopped)
    // and bounds; derive the plausible count span and the range verdict.
    task automatic set_raw(input int c, input int p, input int lo, input int hi);
        per[c] = p;
        if (p == 0) begin
            exp_mn[c] = 0;
            exp_mx[c] = TOL;
        end else begin
            exp_mn[c] = WIN_NS / p - TOL;
            if (exp_mn[c] < 0) exp_mn[c] = 0;
            exp_mx[c] = (WIN_NS + p - 1) / p + TOL;
        end
        lo_thr[c*CNT_W +: CNT_W] = CNT_W'(lo);
        hi_thr[c*CNT_W +: CNT_W] = CNT_W'(hi);
        exp_in[c] = (lo <= exp_mn[c]) && (exp_mx[c] <= hi);
    endtask

    // Random period and bounds placed clearly inside, below, above or
    // inverted, so the verdict never hinges on the count slack.
    task automatic rand_chan(input int c);
        int p, k, r, mn, mx, lo, hi;
        p = pers[$urandom_range(0, 4)];
        set_raw(c, p, 0, 0);
        mn = exp_mn[c];
        mx = exp_mx[c];
        k = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 3));
        r = $urandom_range(0, 3);
        case (k)
            0: begin
                lo = (mn > r) ? mn - r : 0;
                hi = mx + r;
            end
            1: begin
                lo = mx + 1 + r;
                hi = lo + int'($urandom_range(0, 20));
            end
            2: begin
                if (mn >= 1) begin
                    hi = mn - 1;
                    lo = (hi > r) ? hi - r : 0;
                end else begin
                    hi = 5;
                    lo = 9;
                end
            end
            default: begin
                hi = $urandom_range(0, 60);
                lo = hi + 1 + r;
            end
        endcase
        set_raw(c, p, lo, hi);
    endtask

    task automatic model_reset();
        primed = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            good_run[c] = 0;
            bad_run[c]  = 0;
            vm[c]       = 1'b0;
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_cnt", meas_cnt, 0);
        chk("rst_stb", meas_stb, 0);
        chk("rst_valid", clk_valid, 0);
        chk("rst_chg", valid_chg, 0);
    endtask

    // Advance to just after the next TC and check that window.
    task automatic next_tc();
        logic [N_CH-1:0] ev, ec;
        ev = '0;
        ec = '0;
        repeat (WIN_CYC - 1) @(posedge clk);
        #1;
        chk("stb_idle", meas_stb, 0);
        chk("chg_idle", valid_chg, 0);
        @(posedge clk);
        #1;
        if (!primed) begin
            chk("prime_stb", meas_stb, 0);
            chk("prime_cnt", meas_cnt, 0);
            chk("prime_valid", clk_valid, 0);
            primed = 1'b1;
        end else begin
            chk("stb", meas_stb, 1);
            for (int c = 0; c < N_CH; c++) begin
                bit old;
                old = vm[c];
                chk_rng($sformatf("cnt%0d", c),
                        int'(meas_cnt[c*CNT_W +: CNT_W]), exp_mn[c], exp_mx[c]);
`ifdef CLK_FREQ_MONITOR_HYST_EN
                if (exp_in[c]) begin
                    good_run[c]++;
                    bad_run[c] = 0;
                end else begin
                    bad_run[c]++;
                    good_run[c] = 0;
                end
                if (!vm[c] && good_run[c] > GOOD_WIN) vm[c] = 1'b1;
                else if (vm[c] && bad_run[c] >= BAD_WIN) vm[c] = 1'b0;
`else
                vm[c] = exp_in[c];
`endif
                ev[c] = vm[c];
                ec[c] = vm[c] ^ old;
            end
            chk("valid", clk_valid, ev);
            chk("chg", valid_chg, ec);
        end
    endtask

    initial begin
        model_reset();
        set_raw(0, 100, 22, 30);
        set_raw(1, 50, 45, 56);
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs();
        @(negedge clk);
        rst = 1'b0;

        next_tc();
        repeat (6) next_tc();

        set_raw(0, 160, 22, 30);
        next_tc();
        set_raw(0, 100, 22, 30);
        repeat (6) next_tc();

        set_raw(0, 0, 22, 30);
        repeat (3) next_tc();
        set_raw(0, 100, 22, 30);

        repeat (30) begin
            rand_chan(0);
            rand_chan(1);
            next_tc();
        end

        set_raw(0, 100, 22, 30);
        set_raw(1, 50, 45, 56);
        repeat (7) next_tc();

        repeat (100) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        next_tc();
        repeat (3) next_tc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
